adat_frame_buffer: RTL and testbench

ADAT_FRAME_BUFFER -- requirements
Module: adat_frame_buffer

---
 rtl/adat_pkg.sv | 13 +
 rtl/adat_sample_ram.sv | 24 ++
 rtl/adat_frame_buffer.sv | 170 +++++++++++++++++
 tb/tb_adat_frame_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adat_pkg.sv
// Shared constants and writer-state type for the ADAT frame buffer.
package adat_pkg;

  localparam int unsigned ADAT_CHANNELS    = 8;
  localparam int unsigned SAMPLE_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    WR_WAIT = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/adat_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port, no reset.
module adat_sample_ram
  import adat_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = SAMPLE_W_DEFAULT + 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/adat_frame_buffer.sv
// Frame-atomic ADAT sample FIFO: writer commits whole 8-channel frames, reader
// sees committed words only through a first-word-fall-through output register.
module adat_frame_buffer
  import adat_pkg::*;
#(
  parameter int unsigned DEPTH_FRAMES = 16,
  parameter int unsigned SAMPLE_W     = SAMPLE_W_DEFAULT
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            i2s_running_i,
  input  logic [SAMPLE_W-1:0]             sample_i,
  input  logic [2:0]                      sample_ch_i,
  input  logic                            sample_valid_i,
  output logic [SAMPLE_W-1:0]             out_data_o,
  output logic [2:0]                      out_ch_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [$clog2(DEPTH_FRAMES):0]   frames_o,
  output logic                            overflow_o,
  output logic                            seq_error_o,
  input  logic                            clear_flags_i
);

  localparam int unsigned CAP = DEPTH_FRAMES * ADAT_CHANNELS;
  localparam int unsigned AW  = $clog2(CAP);
  localparam int unsigned FW  = $clog2(DEPTH_FRAMES) + 1;
  localparam int unsigned DW  = SAMPLE_W + 3;
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   ROOM_MAX = (AW+1)'(CAP - ADAT_CHANNELS);
  localparam logic [FW-1:0] FR_ONE   = FW'(1);

  wr_state_e     state, state_nxt;
  logic [2:0]    exp_ch, exp_ch_nxt;
  logic [AW:0]   wr_ptr, wr_ptr_nxt, cm_ptr, cm_ptr_nxt, rd_ptr, rel_ptr;
  logic [AW-1:0] waddr;
  logic          we, start, commit, ovf_set, seq_set, room;
  logic          rd_vld, xfer, load_out, fetch;
  logic [DW-1:0] ram_rdata;

  // Space is measured against words actually handed to the consumer.
  assign room = (cm_ptr - rel_ptr) <= ROOM_MAX;

  always_comb begin
    state_nxt  = state;
    exp_ch_nxt = exp_ch;
    wr_ptr_nxt = wr_ptr;
    cm_ptr_nxt = cm_ptr;
    waddr      = wr_ptr[AW-1:0];
    we         = 1'b0;
    start      = 1'b0;
    commit     = 1'b0;
    ovf_set    = 1'b0;
    seq_set    = 1'b0;
    if (!i2s_running_i) begin
      wr_ptr_nxt = cm_ptr;
      state_nxt  = WR_WAIT;
    end else if (sample_valid_i) begin
      unique case (state)
        WR_WAIT: start = (sample_ch_i == 3'd0);
        WR_FILL: begin
          if (sample_ch_i == exp_ch) begin
            we         = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            exp_ch_nxt = exp_ch + 3'd1;
            if (exp_ch == 3'd7) begin
              commit     = 1'b1;
              cm_ptr_nxt = wr_ptr + PTR_ONE;
              state_nxt  = WR_WAIT;
            end
          end else begin
            wr_ptr_nxt = cm_ptr;
            seq_set    = 1'b1;
            state_nxt  = WR_WAIT;
            start      = (sample_ch_i == 3'd0);
          end
        end
        WR_DROP: begin
          if (sample_ch_i == exp_ch && exp_ch != 3'd7) begin
            exp_ch_nxt = exp_ch + 3'd1;
          end else begin
            seq_set   = (sample_ch_i != exp_ch);
            state_nxt = WR_WAIT;
          end
        end
        default: state_nxt = WR_WAIT;
      endcase
      if (start) begin
        exp_ch_nxt = 3'd1;
        if (room) begin
          we         = 1'b1;
          waddr      = cm_ptr[AW-1:0];
          wr_ptr_nxt = cm_ptr + PTR_ONE;
          state_nxt  = WR_FILL;
        end else begin
          ovf_set   = 1'b1;
          state_nxt = WR_DROP;
        end
      end
    end
  end

  // Fetch may be issued on the commit edge itself: cm_ptr_nxt exposes the new
  // frame one cycle early, and its ch 0 word was written at least 7 edges before.
  assign xfer     = out_valid_o & out_ready_i;
  assign load_out = rd_vld & (~out_valid_o | xfer);
  assign fetch    = (~rd_vld | load_out) & (rd_ptr != cm_ptr_nxt);

  adat_sample_ram #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i ({sample_ch_i, sample_i}),
    .re_i    (fetch),
    .raddr_i (rd_ptr[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= WR_WAIT;
      exp_ch      <= '0;
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      rd_ptr      <= '0;
      rel_ptr     <= '0;
      rd_vld      <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      frames_o    <= '0;
      overflow_o  <= 1'b0;
      seq_error_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      exp_ch      <= exp_ch_nxt;
      wr_ptr      <= wr_ptr_nxt;
      cm_ptr      <= cm_ptr_nxt;
      overflow_o  <= (overflow_o & ~clear_flags_i) | ovf_set;
      seq_error_o <= (seq_error_o & ~clear_flags_i) | seq_set;

      if (fetch) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_vld <= 1'b1;
      end else if (load_out) begin
        rd_vld <= 1'b0;
      end

      if (load_out) begin
        out_valid_o <= 1'b1;
        out_ch_o    <= ram_rdata[DW-1 -: 3];
        out_data_o  <= ram_rdata[SAMPLE_W-1:0];
      end else if (xfer) begin
        out_valid_o <= 1'b0;
      end

      if (xfer) rel_ptr <= rel_ptr + PTR_ONE;

      case ({commit, xfer && (out_ch_o == 3'd7)})
        2'b10:   frames_o <= frames_o + FR_ONE;
        2'b01:   frames_o <= frames_o - FR_ONE;
        default: frames_o <= frames_o;
      endcase
    end
  end

endmodule

// File: tb/tb_adat_frame_buffer.sv
// Scoreboard bench for adat_frame_buffer: expected words are queued as frames commit,
// a forked monitor pops them on every transfer and checks stall stability.
module tb_adat_frame_buffer;

  logic        clk;
  logic        reset_n_i;
  logic        i2s_running_i;
  logic [23:0] sample_i;
  logic [2:0]  sample_ch_i;
  logic        sample_valid_i;
  logic [23:0] out_data_o;
  logic [2:0]  out_ch_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  frames_o;
  logic        overflow_o;
  logic        seq_error_o;
  logic        clear_flags_i;

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];
  logic [31:0] mon_held;
  bit          mon_stall;
  bit          rand_on;
  int          peak;

  adat_frame_buffer #(
    .DEPTH_FRAMES (16),
    .SAMPLE_W     (24)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .i2s_running_i  (i2s_running_i),
    .sample_i       (sample_i),
    .sample_ch_i    (sample_ch_i),
    .sample_valid_i (sample_valid_i),
    .out_data_o     (out_data_o),
    .out_ch_o       (out_ch_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .frames_o       (frames_o),
    .overflow_o     (overflow_o),
    .seq_error_o    (seq_error_o),
    .clear_flags_i  (clear_flags_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the strobe dropped.
  task automatic send(input logic [2:0] ch, input logic [23:0] d);
    sample_i       = d;
    sample_ch_i    = ch;
    sample_valid_i = 1'b1;
    @(posedge clk);
    #1;
    sample_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] base, input bit push);
    for (int c = 0; c < 8; c++) send(3'(c), base + 24'(c));
    if (push)
      for (int c = 0; c < 8; c++) exp_q.push_back({5'd0, 3'(c), 24'(base + 24'(c))});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_flags_i = 1'b1;
    tick(1);
    clear_flags_i = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, output int pk);
    int n;
    n  = 0;
    pk = int'(frames_o);
    while ((exp_q.size() != 0 || out_valid_o) && n < max_cycles) begin
      tick(1);
      n++;
      if (int'(frames_o) > pk) pk = int'(frames_o);
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    mon_stall      = 1'b0;
    mon_held       = '0;
    rand_on        = 1'b0;
    reset_n_i      = 1'b0;
    i2s_running_i  = 1'b1;
    sample_i       = '0;
    sample_ch_i    = '0;
    sample_valid_i = 1'b0;
    out_ready_i    = 1'b0;
    clear_flags_i  = 1'b0;

    fork
      forever begin : monitor
        @(negedge clk);
        if (!reset_n_i) begin
          mon_stall = 1'b0;
        end else begin
          if (mon_stall)
            check("stall_hold", out_valid_o ? {5'd0, out_ch_o, out_data_o} : 32'hFFFF_FFFF, mon_held);
          mon_stall = out_valid_o && !out_ready_i;
          mon_held  = {5'd0, out_ch_o, out_data_o};
          if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)",
                       {5'd0, out_ch_o, out_data_o}, $time);
            end else begin
              check("word", {5'd0, out_ch_o, out_data_o}, exp_q.pop_front());
            end
          end
        end
      end
      forever begin : ready_gen
        @(posedge clk);
        #1;
        if (rand_on) out_ready_i = ($urandom_range(0, 3) != 0);
      end
      begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values
    tick(3);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_frames", 32'(frames_o), 32'd0);
    check("rst_data", {5'd0, out_ch_o, out_data_o}, 32'd0);
    check("rst_flags", {30'd0, overflow_o, seq_error_o}, 32'd0);
    reset_n_i = 1'b1;

    // Single frame, consumer ready, first-word latency
    out_ready_i = 1'b1;
    send_frame(24'h000001, 1'b1);
    check("f1_frames", 32'(frames_o), 32'd1);
    check("f1_valid_early", 32'(out_valid_o), 32'd0);
    tick(1);
    check("f1_valid", 32'(out_valid_o), 32'd1);
    check("f1_first", {5'd0, out_ch_o, out_data_o}, 32'h0000_0001);
    wait_drain(50, peak);
    check("f1_frames_end", 32'(frames_o), 32'd0);

    // 17 frames into a stalled 16-frame buffer
    out_ready_i = 1'b0;
    for (int k = 1; k <= 17; k++) send_frame(24'(k) << 8, k <= 16);
    tick(2);
    check("full_frames", 32'(frames_o), 32'd16);
    check("full_ovf", 32'(overflow_o), 32'd1);
    check("full_seq", 32'(seq_error_o), 32'd0);
    out_ready_i = 1'b1;
    wait_drain(400, peak);
    check("full_frames_end", 32'(frames_o), 32'd0);
    pulse_clear();
    check("ovf_cleared", 32'(overflow_o), 32'd0);

    // Broken sequence 0,1,2,4 then a good frame
    send(3'd0, 24'hBAD000);
    send(3'd1, 24'hBAD001);
    send(3'd2, 24'hBAD002);
    send(3'd4, 24'hBAD004);
    check("seq_set", 32'(seq_error_o), 32'd1);
    check("seq_frames", 32'(frames_o), 32'd0);
    send_frame(24'h420000, 1'b1);
    wait_drain(50, peak);
    check("seq_peak", 32'(peak), 32'd1);
    pulse_clear();
    check("seq_cleared", 32'(seq_error_o), 32'd0);

    // Clear coinciding with a new sequence error leaves the flag set
    send(3'd0, 24'hBAD100);
    clear_flags_i = 1'b1;
    send(3'd2, 24'hBAD102);
    clear_flags_i = 1'b0;
    check("clr_vs_set", 32'(seq_error_o), 32'd1);
    pulse_clear();

    // Unexpected ch 0 mid-frame restarts a frame in the same cycle
    send(3'd0, 24'hBAD200);
    send(3'd1, 24'hBAD201);
    send(3'd2, 24'hBAD202);
    send_frame(24'h430000, 1'b1);
    wait_drain(50, peak);
    check("restart_seq", 32'(seq_error_o), 32'd1);
    check("restart_peak", 32'(peak), 32'd1);
    pulse_clear();

    // Stream stop mid-frame after a committed frame
    send_frame(24'h610000, 1'b1);
    for (int c = 0; c < 4; c++) send(3'(c), 24'h620000 + 24'(c));
    i2s_running_i = 1'b0;
    tick(1);
    i2s_running_i = 1'b1;
    send_frame(24'h630000, 1'b1);
    wait_drain(80, peak);
    check("stop_seq", 32'(seq_error_o), 32'd0);
    check("stop_frames", 32'(frames_o), 32'd0);

    // 40 frames with a randomly stalling consumer
    rand_on = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_frame(24'h500000 + (24'(k) << 4), 1'b1);
      tick(8);
    end
    rand_on     = 1'b0;
    out_ready_i = 1'b1;
    wait_drain(2000, peak);
    check("rand_ovf", 32'(overflow_o), 32'd0);
    check("rand_frames", 32'(frames_o), 32'd0);

    // Reset while reading with 3 frames committed
    out_ready_i = 1'b0;
    send_frame(24'h710000, 1'b1);
    send_frame(24'h720000, 1'b0);
    send_frame(24'h730000, 1'b0);
    check("pre_rst_frames", 32'(frames_o), 32'd3);
    out_ready_i = 1'b1;
    tick(3);
    out_ready_i = 1'b0;
    @(posedge clk);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid_o), 32'd0);
    check("arst_frames", 32'(frames_o), 32'd0);
    exp_q.delete();
    tick(2);
    reset_n_i   = 1'b1;
    out_ready_i = 1'b1;
    send_frame(24'h800000, 1'b1);
    wait_drain(50, peak);
    check("post_rst_frames", 32'(frames_o), 32'd0);

    tick(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
